// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS field positions, opcodes and fetch FSM encoding
package mips_pkg;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  // All-zero word decodes as sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Word-align an address by clearing the two byte-offset bits
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fields.sv
// rtl/instr_fields.sv - combinational split of a MIPS instruction word into its fields
module instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [25:0] target26
);

  assign opcode   = ir[OPCODE_HI:OPCODE_LO];
  assign rs       = ir[RS_HI:RS_LO];
  assign rt       = ir[RT_HI:RT_LO];
  assign rd       = ir[RD_HI:RD_LO];
  assign shamt    = ir[SHAMT_HI:SHAMT_LO];
  assign func     = ir[FUNC_HI:FUNC_LO];
  assign imm16    = ir[IMM_HI:IMM_LO];
  assign target26 = ir[TARGET_HI:TARGET_LO];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch FSM with instruction register and redirect handling
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  ir;
  logic [31:0]  pend_pc;
  logic [31:0]  redir_tgt;

  assign redir_tgt = word_align(redirect_pc);

  // pc is a register and only moves when no request is outstanding, so it
  // doubles as the stable registered fetch address
  assign imem_addr = pc;

  // Fetch FSM: issue request, capture word, hold for decode, swallow stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      ir          <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      pend_pc     <= 32'h0000_0000;
    end else begin
      case (state)
        REQ: begin
          if (!imem_req) begin
            // First cycle out of reset: nothing outstanding, start fetching
            imem_req <= 1'b1;
            if (redirect_valid) pc <= redir_tgt;
          end else if (redirect_valid) begin
            if (imem_ready) begin
              // Response arrives with the redirect: drop it, refetch at target
              pc <= redir_tgt;
            end else begin
              pend_pc <= redir_tgt;
              state   <= DISCARD;
            end
          end else if (imem_ready) begin
            ir          <= imem_rdata;
            pc_out      <= pc;
            pc          <= pc + 32'd4;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            pc          <= redir_tgt;
            imem_req    <= 1'b1;
            state       <= REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        DISCARD: begin
          if (redirect_valid) pend_pc <= redir_tgt;
          if (imem_ready) begin
            // Stale response retired; the newest redirect target wins
            pc    <= redirect_valid ? redir_tgt : pend_pc;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  instr_fields u_fields (
    .ir       (ir),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .func     (func),
    .imm16    (imm16),
    .target26 (target26)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        imem_ready;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, pc_out;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target26;

  logic        imem_req2, instr_valid2;
  logic [31:0] imem_addr2, imem_rdata2, pc_out2;
  logic [5:0]  opcode2, func2;
  logic [4:0]  rs2, rt2, rd2, shamt2;
  logic [15:0] imm16_2;
  logic [25:0] target26_2;

  int total;
  int bad;

  // Memory image: address 0 holds add $8,$9,$10; all others lw-style words tagged with their address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h012A_4020;
    return 32'h8C00_0000 | {16'h0, a[15:0]};
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imm16(imm16), .target26(target26), .pc_out(pc_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready), .imem_rdata(imem_rdata2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready),
    .opcode(opcode2), .rs(rs2), .rt(rt2), .rd(rd2), .shamt(shamt2), .func(func2),
    .imm16(imm16_2), .target26(target26_2), .pc_out(pc_out2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    imem_ready = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Reset values
    step(); step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_opcode", {26'h0, opcode}, 32'h0);
    chk("rst_target", {6'h0, target26}, 32'h0);

    // First request after release goes to 0x0
    rst_n = 1'b1;
    step();
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // Sequential zero-wait fetch
    imem_ready = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("seq0_valid", {31'h0, instr_valid}, 32'h1);
    chk("seq0_opcode", {26'h0, opcode}, 32'h0);
    chk("seq0_rs", {27'h0, rs}, 32'd9);
    chk("seq0_rt", {27'h0, rt}, 32'd10);
    chk("seq0_rd", {27'h0, rd}, 32'd8);
    chk("seq0_shamt", {27'h0, shamt}, 32'd0);
    chk("seq0_func", {26'h0, func}, 32'h20);
    chk("seq0_pc_out", pc_out, 32'h0);
    chk("seq0_req_low", {31'h0, imem_req}, 32'h0);
    step();
    chk("seq1_req", {31'h0, imem_req}, 32'h1);
    chk("seq1_addr", imem_addr, 32'h4);
    chk("seq1_valid", {31'h0, instr_valid}, 32'h0);
    step();
    chk("seq1_data_valid", {31'h0, instr_valid}, 32'h1);
    chk("seq1_pc_out", pc_out, 32'h4);
    chk("seq1_opcode", {26'h0, opcode}, 32'h23);
    chk("seq1_imm", {16'h0, imm16}, 32'h4);
    step();
    chk("seq2_addr", imem_addr, 32'h8);
    chk("seq2_req", {31'h0, imem_req}, 32'h1);

    // Wait states on the fetch of 0x8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", {31'h0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_valid", {31'h0, instr_valid}, 32'h0);
    end
    imem_ready = 1'b1;
    instr_ready = 1'b0;
    step();
    imem_ready = 1'b0;
    chk("ws_valid", {31'h0, instr_valid}, 32'h1);
    chk("ws_pc_out", pc_out, 32'h8);

    // Backpressure: everything held, no new fetch
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", {31'h0, instr_valid}, 32'h1);
      chk("bp_pc_out", pc_out, 32'h8);
      chk("bp_imm", {16'h0, imm16}, 32'h8);
      chk("bp_req", {31'h0, imem_req}, 32'h0);
    end
    instr_ready = 1'b1;
    step();
    chk("bp_done_valid", {31'h0, instr_valid}, 32'h0);
    chk("bp_next_req", {31'h0, imem_req}, 32'h1);
    chk("bp_next_addr", imem_addr, 32'hC);

    // Redirect in REQ while the fetch is waiting
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("disc_addr", imem_addr, 32'hC);
    chk("disc_req", {31'h0, imem_req}, 32'h1);
    step();
    chk("disc_addr2", imem_addr, 32'hC);
    imem_ready = 1'b1;
    step();
    chk("disc_drop_valid", {31'h0, instr_valid}, 32'h0);
    chk("disc_new_addr", imem_addr, 32'h100);
    chk("disc_new_req", {31'h0, imem_req}, 32'h1);

    // Redirect in REQ with imem_ready high in the same cycle
    redirect_valid = 1'b1;
    redirect_pc = 32'h180;
    step();
    redirect_valid = 1'b0;
    chk("rdy_redir_valid", {31'h0, instr_valid}, 32'h0);
    chk("rdy_redir_addr", imem_addr, 32'h180);
    chk("rdy_redir_req", {31'h0, imem_req}, 32'h1);
    step();
    chk("rdy_redir_fetch", {31'h0, instr_valid}, 32'h1);
    chk("rdy_redir_pc_out", pc_out, 32'h180);

    // Redirect in HOLD with instr_ready high; low bits of target forced to 0
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'h0, instr_valid}, 32'h0);
    chk("hold_redir_req", {31'h0, imem_req}, 32'h1);
    chk("hold_redir_addr", imem_addr, 32'h200);
    step();
    chk("hold_redir_pc_out", pc_out, 32'h200);
    step();
    chk("after_200_addr", imem_addr, 32'h204);

    // Two redirects while discarding: the last one wins
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    chk("lastwin_hold_addr", imem_addr, 32'h204);
    imem_ready = 1'b1;
    step();
    chk("lastwin_addr", imem_addr, 32'h400);
    chk("lastwin_valid", {31'h0, instr_valid}, 32'h0);

    // Asynchronous reset mid-DISCARD (ir still holds the 0x200 word)
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    step();
    redirect_valid = 1'b0;
    chk("pre_rst_imm", {16'h0, imm16}, 32'h200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_pc_out", pc_out, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_imm", {16'h0, imm16}, 32'h0);
    chk("arst_opcode", {26'h0, opcode}, 32'h0);

    // PC wrap from 0xFFFF_FFFC
    step();
    rst2_n = 1'b1;
    imem_ready = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("wrap_req", {31'h0, imem_req2}, 32'h1);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    step();
    chk("wrap_valid", {31'h0, instr_valid2}, 32'h1);
    chk("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("wrap_imm", {16'h0, imm16_2}, 32'hFFFC);
    step();
    chk("wrap_addr1", imem_addr2, 32'h0);
    chk("wrap_req1", {31'h0, imem_req2}, 32'h1);
    step();
    chk("wrap_pc_out1", pc_out2, 32'h0);
    chk("wrap_rd1", {27'h0, rd2}, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
